// File: rtl/jpeg_byte_serializer.sv
// Purpose: unstuffs a JPEG entropy-coded byte stream, reports markers/EOI and serializes data bits MSB first.
// Latency: a data byte accepted at edge t drives serial_out during cycles t+1..t+8; marker pulses land in cycle t+1.
// Backpressure: byte_ready_out rises only when at most one bit is left, so the bit stream never stalls; none downstream.
//
// Ports:
//   clk_in, rst_in              - clock (rising edge) and asynchronous active-low reset
//   byte_in, byte_valid_in      - input byte stream, valid/ready handshake with byte_ready_out
//   serial_out, serial_valid_out- one bit per cycle toward jpeg_decoder
//   marker_out, marker_valid_out- last marker code (second byte) and one-cycle update pulse
//   eoi_out                     - one-cycle pulse on an FFD9 marker
module jpeg_byte_serializer #(
  parameter bit EOI_HALT = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic       byte_ready_out,
  output logic       serial_out,
  output logic       serial_valid_out,
  output logic [7:0] marker_out,
  output logic       marker_valid_out,
  output logic       eoi_out
);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic       ff_pend, ff_pend_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [3:0] rem, rem_nxt;
  logic [7:0] marker_nxt;
  logic       marker_vld_nxt;
  logic       eoi_nxt;
  logic       accept;

  // Ready while the last bit is on the wire so a new byte lands exactly as
  // the old one finishes, giving a gapless bit stream.
  assign byte_ready_out = (state == RUN) && (rem <= 4'd1);
  assign accept         = byte_valid_in && byte_ready_out;

  // Bit outputs are decoded straight from the registers, so an asynchronous
  // reset silences them without waiting for a clock edge.
  assign serial_valid_out = (rem != 4'd0);
  assign serial_out       = serial_valid_out & shreg[7];

  always_comb begin
    state_nxt      = state;
    ff_pend_nxt    = ff_pend;
    shreg_nxt      = shreg;
    rem_nxt        = rem;
    marker_nxt     = marker_out;
    marker_vld_nxt = 1'b0;
    eoi_nxt        = 1'b0;

    // Draining continues in both states; a load below overrides the final shift.
    if (rem != 4'd0) begin
      shreg_nxt = {shreg[6:0], 1'b0};
      rem_nxt   = rem - 4'd1;
    end

    case (state)
      RUN: begin
        if (accept) begin
          if (!ff_pend) begin
            if (byte_in == 8'hFF) begin
              ff_pend_nxt = 1'b1;
            end else begin
              shreg_nxt = byte_in;
              rem_nxt   = 4'd8;
            end
          end else if (byte_in == 8'h00) begin
            // FF00 is a stuffed literal FF
            shreg_nxt   = 8'hFF;
            rem_nxt     = 4'd8;
            ff_pend_nxt = 1'b0;
          end else if (byte_in != 8'hFF) begin
            // FF followed by anything but 00/FF is a marker; extra FFs are fill
            ff_pend_nxt    = 1'b0;
            marker_nxt     = byte_in;
            marker_vld_nxt = 1'b1;
            if (byte_in == 8'hD9) begin
              eoi_nxt = 1'b1;
              if (EOI_HALT) begin
                state_nxt = DONE;
              end
            end
          end
        end
      end
      DONE: begin
        // Terminal until reset; only the drain above is active.
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= RUN;
      ff_pend          <= 1'b0;
      shreg            <= 8'h00;
      rem              <= 4'd0;
      marker_out       <= 8'h00;
      marker_valid_out <= 1'b0;
      eoi_out          <= 1'b0;
    end else begin
      state            <= state_nxt;
      ff_pend          <= ff_pend_nxt;
      shreg            <= shreg_nxt;
      rem              <= rem_nxt;
      marker_out       <= marker_nxt;
      marker_valid_out <= marker_vld_nxt;
      eoi_out          <= eoi_nxt;
    end
  end

endmodule

// File: doc/jpeg_byte_serializer.md
# jpeg_byte_serializer

Upstream feeder for `jpeg_decoder`. It accepts the JPEG entropy-coded segment one byte at a time over a valid/ready handshake and removes `0xFF00` byte stuffing. It detects and reports markers, including restart markers and EOI, and drives the decoder's `serial_in`/`valid_in` with one bit per cycle, MSB first.

## Interface

- `EOI_HALT`, default 1. 1: after EOI the block stops accepting bytes until reset. 0: after EOI it returns to normal operation.

Ports:

- `clk_in` input 1: system clock; all state on rising edge.
- `rst_in` input 1: reset; one clock, asynchronous, active-low.
- `byte_in` input 8: next byte of the entropy-coded stream.
- `byte_valid_in` input 1: `byte_in` valid; must hold byte stable until accepted.
- `byte_ready_out` output 1: block accepts `byte_in` this cycle if `byte_valid_in`; combinational from state.
- `serial_out` output 1: bitstream bit, to `jpeg_decoder.serial_in`.
- `serial_valid_out` output 1: `serial_out` valid, to `jpeg_decoder.valid_in`.
- `marker_out` output 8: code of the last detected marker (second byte, e.g. `0xD0`, `0xD9`).
- `marker_valid_out` output 1: one-cycle pulse when `marker_out` updates.
- `eoi_out` output 1: one-cycle pulse when `0xFFD9` is detected.

## Operation

- Accept = `byte_valid_in && byte_ready_out` at a rising edge.

State:
- `state` ∈ {RUN, DONE}.
- `ff_pend` flag: the previous accepted byte was `0xFF`.
- `shreg[7:0]`.
- `rem[3:0]`: bits left to emit, 0..8.

Byte classification on accept, in RUN:
- `ff_pend=0`, byte ≠ `FF`: load `shreg`←byte, `rem`←8.
- `ff_pend=0`, byte = `FF`: set `ff_pend`; nothing emitted.
- `ff_pend=1`, byte = `00`: stuffed data. Load `shreg`←`FF`, `rem`←8, clear `ff_pend`.
- `ff_pend=1`, byte = `FF`: fill byte. Keep `ff_pend`; nothing emitted.
- `ff_pend=1`, any other byte: marker.
  - Clear `ff_pend`, `marker_out`←byte, pulse `marker_valid_out`.
  - If byte = `D9`: also pulse `eoi_out`; `state`←DONE if `EOI_HALT=1`, else stay RUN.
  - Nothing emitted for marker bytes.

Emission:
- Each cycle `rem>0`: `serial_out`←`shreg[7]`, `serial_valid_out`←1, `shreg`←`shreg<<1`, `rem`←`rem-1`.
- Otherwise `serial_valid_out`←0 and `serial_out`←0.
- A load on the same edge as the last bit's shift takes priority. The new byte's MSB is emitted on the following cycle, so a continuous stream gives gapless bits.

Ready:
- `byte_ready_out = (state==RUN) && (rem<=1)`.
- When `rem<=1`, bytes that emit nothing (`FF`, fill bytes, markers) are also accepted at that rate.

DONE:
- `byte_ready_out=0`; no bits emitted.
- Remaining bits of a byte already loaded still drain.
- Leaves only on reset.

No downstream backpressure: the decoder consumes one bit per cycle unconditionally.

Reset values:
- `state`=RUN, `ff_pend`=0, `rem`=0, `shreg`=0.
- `serial_out`=0, `serial_valid_out`=0, `marker_out`=0, `marker_valid_out`=0, `eoi_out`=0.
- `byte_ready_out`=1 once reset is released.

## Timing

- Data byte accepted at edge t: its bits appear on `serial_out` with `serial_valid_out=1` during cycles t+1 … t+8, MSB first.
- Marker byte accepted at edge t: `marker_valid_out` (and `eoi_out` if `D9`) is high during cycle t+1 only.
- Throughput: one data byte per 8 cycles. `byte_ready_out` is high in the cycle holding the last bit (`rem==1`), allowing back-to-back accepts.
- A stuffed `FF 00` pair costs 2 accepts but produces 8 bits. The cycle between them shows `serial_valid_out=0` unless earlier bits are still draining.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous), and a pending `FF` is discarded. After release, a `00` byte is plain data, not stuffing.
- `byte_valid_in` dropping between bytes: `serial_valid_out` deasserts once `rem` reaches 0 and resumes 1 cycle after the next accept.
- `FF` as the last byte before a gap: `ff_pend` holds indefinitely until the next byte arrives.

## Test plan

- Bytes `A5`, `3C` with `byte_valid_in` held high → 16 consecutive valid bits `1010_0101_0011_1100`, no gap. `byte_ready_out` is high at reset release and in the cycle emitting bit 8 of `A5`.
- Bytes `FF`, `00`, `81` → bits `1111_1111_1000_0001` only. No marker pulse.
- Bytes `FF`, `FF`, `FF`, `D3` → zero bits emitted. One `marker_valid_out` pulse with `marker_out=D3`. `eoi_out` stays 0.
- `EOI_HALT=1`: bytes `12`, `FF`, `D9`, `55` →
  - bits `0001_0010`;
  - `marker_out=D9` with `marker_valid_out` and `eoi_out` pulsing together for one cycle;
  - `byte_ready_out` then stays 0, so `55` is never accepted and no further bits appear.
  - With `EOI_HALT=0` the same stream → `55` is accepted and emits `0101_0101`.
- Byte `C7` accepted; assert `rst_in` low after 3 bits are emitted → `serial_valid_out` drops without waiting for an edge. After release, bytes `FF`, (reset pulse), `00` → `00` emits `0000_0000`, not treated as stuffing.
- Randomized `byte_valid_in` gaps over a 64-byte stream containing stuffing and `D0`–`D7` restart markers → the emitted bitstream equals a reference unstuffer's output. One marker pulse per marker, in order.
